lsu_wb_master: RTL
==================

Name: lsu_wb_master

Overview:
- Single-port Wishbone (pipelined) bus master for the core's load/store path.
- Sits directly upstream of the dual-port data memory model and drives one of its ports.
- Accepts byte, half and word requests from the core.
- Generates an aligned word address, byte selects and lane-replicated write data.
- Runs one bus cycle per request and returns extracted, sign- or zero-extended load data or an error.

Parameters:
- ADDR_WIDTH, 32, width of req_addr_i and wb_adr_o.
- TIMEOUT_CYCLES, 255, cycles to wait for ack/err before aborting (used only with LSU_TIMEOUT_EN).
- TO_WIDTH, 8, width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1=store, 0=load.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_size_i  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned_i  in  1  loads: 1=zero-extend, 0=sign-extend.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  response is an error.
- rsp_misalign_o  out  1  error cause: misaligned or illegal size.
- rsp_timeout_o  out  1  error cause: bus timeout.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  ADDR_WIDTH  byte address with [1:0] forced to 0.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  bus error.
- wb_stall_i  in  1  slave stall.

Behaviour:
- Reset, applied on the edge where wb_rst_i=1:
  - State goes to IDLE.
  - All outputs are 0, including req_ready_o.
  - The timeout counter is cleared.
  - An in-flight bus cycle is abandoned; a later ack/err with wb_cyc_o=0 is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On valid&ready, latch all request fields.
  - Go to REQ if aligned and size is legal; otherwise go to RESP with rsp_err_o=1 and rsp_misalign_o=1, and issue no bus activity.
- Alignment rules:
  - half requires addr[0]=0.
  - word requires addr[1:0]=00.
  - size=11 is always illegal.
- REQ:
  - wb_cyc_o=wb_stb_o=1; adr, we, sel and dat are driven from latched values and held stable.
  - If wb_stall_i=0, the strobe is accepted; go to WAIT with stb=0 and cyc=1.
  - If wb_ack_i or wb_err_i is also seen in the accepting cycle, go directly to RESP.
  - If wb_stall_i=1, stay in REQ.
- WAIT:
  - cyc=1, stb=0.
  - On wb_err_i, go to RESP with rsp_err_o=1. If ack and err arrive together, err wins.
  - On wb_ack_i, capture wb_dat_i and go to RESP.
  - Stays in WAIT indefinitely unless timeout is enabled.
- RESP:
  - cyc=0, rsp_valid_o=1 for exactly one cycle, then return to IDLE.
  - No response back-pressure; req_ready_o=0.
- Lane steering, keyed on addr[1:0]:
  - Byte: sel=0001<<addr[1:0]; dat_o={4{wdata[7:0]}}.
  - Half: sel=0011 when addr[1]=0, 1100 when addr[1]=1; dat_o={2{wdata[15:0]}}.
  - Word: sel=1111; dat_o=wdata.
- Load extraction:
  - Select the byte lane or half lane by addr, then extend per req_unsigned_i.
  - Word loads pass through unchanged.
- Latency against a zero-stall slave that acks one cycle after the strobe:
  - Accept at cycle N; stb is high in N+1; ack arrives in N+2; rsp_valid_o is high in N+3.
  - Next acceptance can occur at N+4.
- Error responses force rsp_rdata_o=0. Only one outstanding transaction at any time.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without ack/err, drop cyc/stb and go to RESP with rsp_err_o=1 and rsp_timeout_o=1.
  - An ack arriving on the same cycle as expiry wins; no timeout is reported.
- Undefined: there is no counter, rsp_timeout_o is tied to 0, and WAIT/REQ may persist forever.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load 0x10 -> wb_sel_o=1111, wb_adr_o=0x10; load rsp_rdata_o=0xDEADBEEF, rsp_valid_o 3 cycles after accept.
- Byte store 0x80 to 0x13, then signed and unsigned byte loads of 0x13 -> sel=1000, dat_o=0x80808080; rdata 0xFFFFFF80 (signed) and 0x00000080 (unsigned).
- Half load addr 0x12 after a word store 0x8001_1234 to 0x10 -> sel=1100; signed rdata=0xFFFF8001.
- Misaligned half at 0x11, word at 0x22, and size=11 -> no wb_cyc_o; rsp_valid_o next cycle with err=1, misalign=1, rdata=0.
- wb_stall_i held 3 cycles, then wb_err_i together with wb_ack_i -> stb held stable with constant adr/sel during stall; response err=1.
- wb_rst_i pulsed while in WAIT, then a stale ack -> outputs 0 and IDLE after the edge, no rsp_valid_o. With LSU_TIMEOUT_EN and ack never given -> rsp_timeout_o=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: single-outstanding pipelined Wishbone master for the core's
// load/store path. Converts byte/half/word requests into one aligned bus cycle
// and returns extracted, extended load data or an error.
// Optional bus timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu_wb_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_WIDTH       = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_misalign_o,
    output logic                  rsp_timeout_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    output logic [3:0]            wb_sel_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_stall_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, uns_q, err_q, mis_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q, rdata_q;
    logic                  accept, legal, take_ack, take_err;

    // Half needs addr[0]=0, word needs addr[1:0]=0, size 11 never legal.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            2'b10:   return (a == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so sel alone picks the bytes.
    function automatic logic [31:0] lane_dat(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] size,
                                             input logic [1:0] a, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   return {{24{~uns & b[7]}}, b};
            2'b01:   return {{16{~uns & h[15]}}, h};
            default: return d;
        endcase
    endfunction

    assign legal = is_legal(req_size_i, req_addr_i[1:0]);

`ifdef LSU_TIMEOUT_EN
    logic [TO_WIDTH-1:0] cnt_q;
    logic                expire, take_to, to_q;

    assign expire = (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    // Cycle counter for the current bus cycle; restarts on every acceptance.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= '0;
        else if (state_q == ST_REQ || state_q == ST_WAIT)
            cnt_q <= cnt_q + 1'b1;
    end

    assign rsp_timeout_o = rsp_valid_o & to_q;
`else
    logic unused_cfg;
    assign unused_cfg    = (TIMEOUT_CYCLES > 0) ^ (TO_WIDTH > 0);
    assign rsp_timeout_o = 1'b0;
`endif

    // State register; reset abandons any in-flight bus cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        take_ack    = 1'b0;
        take_err    = 1'b0;
`ifdef LSU_TIMEOUT_EN
        take_to     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready_o = ~wb_rst_i;
                if (req_valid_i && !wb_rst_i) begin
                    accept  = 1'b1;
                    state_d = legal ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (!wb_stall_i) begin
                    state_d = ST_WAIT;
                    if (wb_err_i) begin
                        take_err = 1'b1;
                        state_d  = ST_RESP;
                    end else if (wb_ack_i) begin
                        take_ack = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                wb_cyc_o = 1'b1;
                if (wb_err_i) begin
                    take_err = 1'b1;
                    state_d  = ST_RESP;
                end else if (wb_ack_i) begin
                    take_ack = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef LSU_TIMEOUT_EN
        // A same-cycle ack or err beats expiry.
        if ((state_q == ST_REQ || state_q == ST_WAIT) && !take_ack && !take_err && expire) begin
            take_to = 1'b1;
            state_d = ST_RESP;
        end
`endif
    end

    // Request fields and response payload; only visible through state-gated outputs.
    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            we_q   <= req_we_i;
            addr_q <= req_addr_i;
            size_q <= req_size_i;
            uns_q  <= req_unsigned_i;
            sel_q  <= lane_sel(req_size_i, req_addr_i[1:0]);
            dat_q  <= lane_dat(req_size_i, req_wdata_i);
            err_q  <= ~legal;
            mis_q  <= ~legal;
`ifdef LSU_TIMEOUT_EN
            to_q   <= 1'b0;
`endif
        end
        if (take_ack)
            rdata_q <= we_q ? 32'h0 : load_ext(wb_dat_i, size_q, addr_q[1:0], uns_q);
        if (take_err)
            err_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
        if (take_to) begin
            err_q <= 1'b1;
            to_q  <= 1'b1;
        end
`endif
    end

    assign wb_we_o        = wb_cyc_o & we_q;
    assign wb_adr_o       = wb_cyc_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign wb_sel_o       = wb_cyc_o ? sel_q : 4'b0000;
    assign wb_dat_o       = wb_cyc_o ? dat_q : 32'h0;
    assign rsp_rdata_o    = (rsp_valid_o && !err_q) ? rdata_q : 32'h0;
    assign rsp_err_o      = rsp_valid_o & err_q;
    assign rsp_misalign_o = rsp_valid_o & mis_q;

endmodule
